// File: rtl/sprite_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_engine
//  Description : VGA sprite demo. 640x480@60 scan timing, a 256x256
//                playfield holding one 16x16 2bpp sprite drawn 2x, moved
//                once per frame by four switches, sprite X on two 7-seg
//                digits, scan position and pixel code exported for capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_engine #(
  parameter int H_ACTIVE  = 640,
  parameter int H_TOTAL   = 800,
  parameter int HS_START  = 656,
  parameter int HS_END    = 752,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 525,
  parameter int VS_START  = 490,
  parameter int VS_END    = 492,
  parameter int PF_X      = 100,
  parameter int PF_SIZE   = 256,
  parameter int SPR_START = 112
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic       o_VGA_Red_0,
  output logic       o_VGA_Red_1,
  output logic       o_VGA_Red_2,
  output logic       o_VGA_Grn_0,
  output logic       o_VGA_Grn_1,
  output logic       o_VGA_Grn_2,
  output logic       o_VGA_Blu_0,
  output logic       o_VGA_Blu_1,
  output logic       o_VGA_Blu_2,
  output logic       o_Segment1_A,
  output logic       o_Segment1_B,
  output logic       o_Segment1_C,
  output logic       o_Segment1_D,
  output logic       o_Segment1_E,
  output logic       o_Segment1_F,
  output logic       o_Segment1_G,
  output logic       o_Segment2_A,
  output logic       o_Segment2_B,
  output logic       o_Segment2_C,
  output logic       o_Segment2_D,
  output logic       o_Segment2_E,
  output logic       o_Segment2_F,
  output logic       o_Segment2_G,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [9:0] tb_row,
  output logic [9:0] tb_column,
  output logic [1:0] tb_pixel
);

  localparam logic [9:0] c_H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_H_ACTIVE  = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACTIVE  = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_START  = 10'(HS_START);
  localparam logic [9:0] c_HS_END    = 10'(HS_END);
  localparam logic [9:0] c_VS_START  = 10'(VS_START);
  localparam logic [9:0] c_VS_END    = 10'(VS_END);
  localparam logic [9:0] c_PF_X      = 10'(PF_X);
  localparam logic [9:0] c_PF_END    = 10'(PF_X + PF_SIZE);
  localparam logic [9:0] c_PF_SIZE   = 10'(PF_SIZE);
  localparam logic [7:0] c_SPR_START = 8'(SPR_START);
  localparam logic [7:0] c_SPR_MAX   = 8'(PF_SIZE - 32);

  // Sprite bitmap: border ring is code 3, both diagonals code 1, fill code 2.
  // Entry for (u,v) lives at bit index 2*(16*v+u).
  function automatic logic [511:0] f_build_rom();
    logic [511:0] rom;
    logic [3:0]   u;
    logic [3:0]   v;
    rom = '0;
    for (int i = 0; i < 256; i++) begin
      u = 4'(i % 16);
      v = 4'(i / 16);
      if (u == 4'd0 || u == 4'd15 || v == 4'd0 || v == 4'd15)
        rom[2*i +: 2] = 2'd3;
      else if (u == v || ({1'b0, u} + {1'b0, v}) == 5'd15)
        rom[2*i +: 2] = 2'd1;
      else
        rom[2*i +: 2] = 2'd2;
    end
    return rom;
  endfunction

  localparam logic [511:0] c_ROM = f_build_rom();

  // Hex digit to segments {A,B,C,D,E,F,G}, active-low.
  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    logic [6:0] lit;
    case (d)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      default: lit = 7'b1000111;
    endcase
    return ~lit;
  endfunction

  logic [9:0] r_column;
  logic [9:0] r_row;
  logic [7:0] r_sprite_x;
  logic [7:0] r_sprite_y;
  logic [3:0] r_sw_meta;
  logic [3:0] r_sw_sync;
  logic       r_hsync;
  logic       r_vsync;
  logic [2:0] r_red;
  logic [2:0] r_grn;
  logic [2:0] r_blu;

  logic [9:0] w_px;
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic       w_in_pf;
  logic       w_active;
  logic       w_hit;
  logic [3:0] w_u;
  logic [3:0] w_v;
  logic [1:0] w_code;
  logic       w_move_tick;
  logic [2:0] w_red;
  logic [2:0] w_grn;
  logic [2:0] w_blu;
  logic [6:0] w_seg1;
  logic [6:0] w_seg2;

  // Scan counters: column every clock, row advances on column wrap.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_column <= '0;
      r_row    <= '0;
    end else if (r_column == c_H_LAST) begin
      r_column <= '0;
      r_row    <= (r_row == c_V_LAST) ? 10'd0 : r_row + 10'd1;
    end else begin
      r_column <= r_column + 10'd1;
    end
  end

  // Playfield and sprite hit geometry; px wraps when left of the playfield
  // but is then masked by w_in_pf.
  assign w_px     = r_column - c_PF_X;
  assign w_in_pf  = (r_column >= c_PF_X) && (r_column < c_PF_END) && (r_row < c_PF_SIZE);
  assign w_active = (r_column < c_H_ACTIVE) && (r_row < c_V_ACTIVE);
  assign w_dx     = w_px - {2'b00, r_sprite_x};
  assign w_dy     = r_row - {2'b00, r_sprite_y};
  assign w_hit    = w_in_pf && (w_px >= {2'b00, r_sprite_x}) && (w_dx < 10'd32)
                 && (r_row >= {2'b00, r_sprite_y}) && (w_dy < 10'd32);
  assign w_u      = w_dx[4:1];
  assign w_v      = w_dy[4:1];
  assign w_code   = c_ROM[{w_v, w_u, 1'b0} +: 2];
  assign tb_pixel = w_hit ? w_code : 2'b00;

  // Pixel colour from the current scan position.
  always_comb begin
    w_red = 3'd0;
    w_grn = 3'd0;
    w_blu = 3'd0;
    if (w_active) begin
      case (tb_pixel)
        2'd1: w_red = 3'd7;
        2'd2: w_grn = 3'd7;
        2'd3: begin
          w_red = 3'd7;
          w_grn = 3'd7;
          w_blu = 3'd7;
        end
        default: if (w_in_pf) w_blu = 3'd2;
      endcase
    end
  end

  // Colour and syncs registered together so they stay mutually aligned.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_red   <= '0;
      r_grn   <= '0;
      r_blu   <= '0;
    end else begin
      r_hsync <= !((r_column >= c_HS_START) && (r_column < c_HS_END));
      r_vsync <= !((r_row >= c_VS_START) && (r_row < c_VS_END));
      r_red   <= w_red;
      r_grn   <= w_grn;
      r_blu   <= w_blu;
    end
  end

  // Two-stage switch synchronizer, bit n-1 carries switch n.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
      r_sw_sync <= r_sw_meta;
    end
  end

  assign w_move_tick = (r_row == c_V_ACTIVE) && (r_column == 10'd0);

  // Sprite moves one step per frame at the start of vertical blanking,
  // clamped to the playfield; opposing switches cancel on their axis.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sprite_x <= c_SPR_START;
      r_sprite_y <= c_SPR_START;
    end else if (w_move_tick) begin
      if (r_sw_sync[0] && !r_sw_sync[1] && r_sprite_y != 8'd0)
        r_sprite_y <= r_sprite_y - 8'd1;
      else if (r_sw_sync[1] && !r_sw_sync[0] && r_sprite_y < c_SPR_MAX)
        r_sprite_y <= r_sprite_y + 8'd1;
      if (r_sw_sync[2] && !r_sw_sync[3] && r_sprite_x != 8'd0)
        r_sprite_x <= r_sprite_x - 8'd1;
      else if (r_sw_sync[3] && !r_sw_sync[2] && r_sprite_x < c_SPR_MAX)
        r_sprite_x <= r_sprite_x + 8'd1;
    end
  end

  assign w_seg1 = f_seg7(r_sprite_x[7:4]);
  assign w_seg2 = f_seg7(r_sprite_x[3:0]);

  assign {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D,
          o_Segment1_E, o_Segment1_F, o_Segment1_G} = w_seg1;
  assign {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D,
          o_Segment2_E, o_Segment2_F, o_Segment2_G} = w_seg2;

  assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = r_sw_sync;
  assign o_VGA_HSync = r_hsync;
  assign o_VGA_VSync = r_vsync;
  assign {o_VGA_Red_2, o_VGA_Red_1, o_VGA_Red_0} = r_red;
  assign {o_VGA_Grn_2, o_VGA_Grn_1, o_VGA_Grn_0} = r_grn;
  assign {o_VGA_Blu_2, o_VGA_Blu_1, o_VGA_Blu_0} = r_blu;
  assign tb_row    = r_row;
  assign tb_column = r_column;

endmodule
`default_nettype wire

// File: tb/tb_sprite_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_engine
//  Description : Bench for sprite_engine. A reduced-timing instance is
//                checked cycle by cycle against a reference model through a
//                scoreboard; a full-timing instance gets line-level checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_engine;

  // Reduced geometry so many frames fit in a short run.
  localparam int H_ACTIVE  = 44;
  localparam int H_TOTAL   = 50;
  localparam int HS_START  = 46;
  localparam int HS_END    = 48;
  localparam int V_ACTIVE  = 40;
  localparam int V_TOTAL   = 42;
  localparam int VS_START  = 40;
  localparam int VS_END    = 41;
  localparam int PF_X      = 2;
  localparam int PF_SIZE   = 36;
  localparam int SPR_START = 2;
  localparam int FRAME     = H_TOTAL * V_TOTAL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;

  always #20 clk = ~clk;

  // Reduced instance outputs
  logic       s_hs, s_vs;
  logic [2:0] s_r, s_g, s_b;
  logic [6:0] s_seg1, s_seg2;
  logic [3:0] s_led;
  logic [9:0] s_row, s_col;
  logic [1:0] s_pix;
  // Full-timing instance outputs
  logic       f_hs, f_vs;
  logic [2:0] f_r, f_g, f_b;
  logic [6:0] f_seg1, f_seg2;
  logic [3:0] f_led;
  logic [9:0] f_row, f_col;
  logic [1:0] f_pix;

  sprite_engine #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .HS_START(HS_START), .HS_END(HS_END),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_END(VS_END),
    .PF_X(PF_X), .PF_SIZE(PF_SIZE), .SPR_START(SPR_START)
  ) u_small (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
    .o_VGA_HSync(s_hs), .o_VGA_VSync(s_vs),
    .o_VGA_Red_0(s_r[0]), .o_VGA_Red_1(s_r[1]), .o_VGA_Red_2(s_r[2]),
    .o_VGA_Grn_0(s_g[0]), .o_VGA_Grn_1(s_g[1]), .o_VGA_Grn_2(s_g[2]),
    .o_VGA_Blu_0(s_b[0]), .o_VGA_Blu_1(s_b[1]), .o_VGA_Blu_2(s_b[2]),
    .o_Segment1_A(s_seg1[6]), .o_Segment1_B(s_seg1[5]), .o_Segment1_C(s_seg1[4]),
    .o_Segment1_D(s_seg1[3]), .o_Segment1_E(s_seg1[2]), .o_Segment1_F(s_seg1[1]),
    .o_Segment1_G(s_seg1[0]),
    .o_Segment2_A(s_seg2[6]), .o_Segment2_B(s_seg2[5]), .o_Segment2_C(s_seg2[4]),
    .o_Segment2_D(s_seg2[3]), .o_Segment2_E(s_seg2[2]), .o_Segment2_F(s_seg2[1]),
    .o_Segment2_G(s_seg2[0]),
    .o_LED_1(s_led[0]), .o_LED_2(s_led[1]), .o_LED_3(s_led[2]), .o_LED_4(s_led[3]),
    .tb_row(s_row), .tb_column(s_col), .tb_pixel(s_pix)
  );

  sprite_engine u_full (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
    .o_VGA_HSync(f_hs), .o_VGA_VSync(f_vs),
    .o_VGA_Red_0(f_r[0]), .o_VGA_Red_1(f_r[1]), .o_VGA_Red_2(f_r[2]),
    .o_VGA_Grn_0(f_g[0]), .o_VGA_Grn_1(f_g[1]), .o_VGA_Grn_2(f_g[2]),
    .o_VGA_Blu_0(f_b[0]), .o_VGA_Blu_1(f_b[1]), .o_VGA_Blu_2(f_b[2]),
    .o_Segment1_A(f_seg1[6]), .o_Segment1_B(f_seg1[5]), .o_Segment1_C(f_seg1[4]),
    .o_Segment1_D(f_seg1[3]), .o_Segment1_E(f_seg1[2]), .o_Segment1_F(f_seg1[1]),
    .o_Segment1_G(f_seg1[0]),
    .o_Segment2_A(f_seg2[6]), .o_Segment2_B(f_seg2[5]), .o_Segment2_C(f_seg2[4]),
    .o_Segment2_D(f_seg2[3]), .o_Segment2_E(f_seg2[2]), .o_Segment2_F(f_seg2[1]),
    .o_Segment2_G(f_seg2[0]),
    .o_LED_1(f_led[0]), .o_LED_2(f_led[1]), .o_LED_3(f_led[2]), .o_LED_4(f_led[3]),
    .tb_row(f_row), .tb_column(f_col), .tb_pixel(f_pix)
  );

  int tests = 0;
  int fails = 0;

  // Lit segments per hex digit, letters a..g.
  string seg_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_exp(input int d);
    logic [6:0] lit;
    string      s;
    int         idx;
    lit = '0;
    s = seg_str[d];
    for (int k = 0; k < s.len(); k++) begin
      idx = int'(s[k]) - 97;
      lit[6 - idx] = 1'b1;
    end
    return ~lit;
  endfunction

  function automatic bit in_pf(input int row, input int col);
    return (col >= PF_X) && (col < PF_X + PF_SIZE) && (row < PF_SIZE);
  endfunction

  function automatic logic [1:0] exp_code(input int row, input int col, input int sx, input int sy);
    int px, u, v;
    if (!in_pf(row, col)) return 2'd0;
    px = col - PF_X;
    if (px < sx || px >= sx + 32 || row < sy || row >= sy + 32) return 2'd0;
    u = (px - sx) / 2;
    v = (row - sy) / 2;
    if (u == 0 || u == 15 || v == 0 || v == 15) return 2'd3;
    if (u == v || u + v == 15) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [8:0] exp_rgb(input int row, input int col, input int sx, input int sy);
    if (col >= H_ACTIVE || row >= V_ACTIVE) return 9'd0;
    case (exp_code(row, col, sx, sy))
      2'd1:    return {3'd7, 3'd0, 3'd0};
      2'd2:    return {3'd0, 3'd7, 3'd0};
      2'd3:    return {3'd7, 3'd7, 3'd7};
      default: return in_pf(row, col) ? {3'd0, 3'd0, 3'd2} : 9'd0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: elapsed cycles since reset give the scan position;
  // per-edge expected outputs go to the scoreboard queue.
  logic [50:0] exp_q[$];
  int          m_t, m_sx, m_sy, m_row, m_col;
  logic [3:0]  m_s1, m_s2;
  logic [8:0]  m_rgb;
  logic        m_hs, m_vs;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_t = 0; m_sx = SPR_START; m_sy = SPR_START;
        m_s1 = '0; m_s2 = '0; m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1;
      end else begin
        m_col = m_t % H_TOTAL;
        m_row = (m_t / H_TOTAL) % V_TOTAL;
        m_rgb = exp_rgb(m_row, m_col, m_sx, m_sy);
        m_hs  = !(m_col >= HS_START && m_col < HS_END);
        m_vs  = !(m_row >= VS_START && m_row < VS_END);
        if (m_row == V_ACTIVE && m_col == 0) begin
          if (m_s2[0] ^ m_s2[1])
            m_sy = m_s2[0] ? (m_sy > 0 ? m_sy - 1 : 0) : (m_sy < PF_SIZE - 32 ? m_sy + 1 : m_sy);
          if (m_s2[2] ^ m_s2[3])
            m_sx = m_s2[2] ? (m_sx > 0 ? m_sx - 1 : 0) : (m_sx < PF_SIZE - 32 ? m_sx + 1 : m_sx);
        end
        m_s2 = m_s1;
        m_s1 = sw;
        m_t++;
      end
      m_col = m_t % H_TOTAL;
      m_row = (m_t / H_TOTAL) % V_TOTAL;
      exp_q.push_back({m_hs, m_vs, m_rgb, seg_exp(m_sx / 16), seg_exp(m_sx % 16), m_s2,
                       10'(m_row), 10'(m_col), exp_code(m_row, m_col, m_sx, m_sy)});
    end
  end

  // Monitor: the DUT presents a full output set every clock.
  logic [50:0] act_v, exp_v;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      act_v = {s_hs, s_vs, s_r, s_g, s_b, s_seg1, s_seg2, s_led, s_row, s_col, s_pix};
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (fails < 40) begin
          tests++;
          if (act_v !== exp_v) begin
            fails++;
            $display("FAIL scoreboard row=%0d col=%0d: got %h expected %h",
                     exp_v[21:12], exp_v[11:2], act_v, exp_v);
          end
        end
      end
    end
  end

  task automatic align_frame();
    for (int i = 0; i < FRAME + 5; i++) begin
      @(negedge clk);
      if ((m_t % FRAME) == 10) return;
    end
    tests++; fails++;
    $display("FAIL align: frame offset not reached");
  endtask

  task automatic hold_frames(input logic [3:0] pattern, input int n);
    sw = pattern;
    repeat (n * FRAME) @(negedge clk);
  endtask

  int hs_low, first_low;
  bit saw_last, saw_wrap;

  initial begin
    rst_n = 1'b0;
    sw    = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_full_seg1", int'(f_seg1), int'(seg_exp(7)));
    chk("reset_full_seg2", int'(f_seg2), int'(seg_exp(0)));
    chk("reset_full_hsync", int'(f_hs), 1);
    chk("reset_full_col", int'(f_col), 0);
    chk("reset_small_seg2", int'(s_seg2), int'(seg_exp(2)));
    @(negedge clk);
    rst_n = 1'b1;

    // Full-timing line checks over two lines.
    hs_low = 0; first_low = -1; saw_last = 0; saw_wrap = 0;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk);
      #1;
      if (f_row == 10'd0 && !f_hs) begin
        hs_low++;
        if (first_low < 0) first_low = int'(f_col);
      end
      if (f_row == 10'd0 && f_col == 10'd151) chk("full_rgb_col150", int'({f_r, f_g, f_b}), 2);
      if (f_row == 10'd0 && f_col == 10'd51)  chk("full_rgb_col50", int'({f_r, f_g, f_b}), 0);
      if (f_row == 10'd0 && f_col == 10'd701) chk("full_rgb_col700", int'({f_r, f_g, f_b}), 0);
      if (f_row == 10'd0 && f_col == 10'd799) saw_last = 1;
      if (f_row == 10'd1 && f_col == 10'd0)   saw_wrap = 1;
    end
    chk("full_hsync_width", hs_low, 96);
    chk("full_hsync_first_col", first_low, 657);
    chk("full_col_799", int'(saw_last), 1);
    chk("full_line_wrap", int'(saw_wrap), 1);

    // Directed movement on the reduced instance (clamp at PF_SIZE-32 = 4).
    align_frame();
    hold_frames(4'b1000, 3);
    chk("right_clamp_seg2", int'(s_seg2), int'(seg_exp(4)));
    chk("right_led", int'(s_led), 8);
    hold_frames(4'b0100, 5);
    chk("left_clamp_seg2", int'(s_seg2), int'(seg_exp(0)));
    chk("left_clamp_seg1", int'(s_seg1), int'(seg_exp(0)));
    hold_frames(4'b0010, 3);
    hold_frames(4'b0011, 2);
    hold_frames(4'b0001, 1);

    // Random switch activity at arbitrary times.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(200, 1500)) @(negedge clk);
      sw = 4'($urandom_range(0, 15));
    end

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    chk("async_small_col", int'(s_col), 0);
    chk("async_small_row", int'(s_row), 0);
    chk("async_small_hsync", int'(s_hs), 1);
    chk("async_small_rgb", int'({s_r, s_g, s_b}), 0);
    chk("async_full_col", int'(f_col), 0);
    chk("async_full_hsync", int'(f_hs), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("restart_seg2", int'(s_seg2), int'(seg_exp(2)));
    sw = 4'b1010;
    repeat (FRAME + 100) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
